// File: rtl/divu_hilo.sv
// -----------------------------------------------------------------------------
// divu_hilo
//   Multi-cycle unsigned divider feeding the HI/LO result registers of the ALU.
//   A DIVU function code seen in IDLE latches the operands. The quotient and
//   remainder are then produced by restoring shift-subtract, one bit per cycle.
//   The remainder is published on HiOut and the quotient on LoOut. The
//   downstream result-select mux reads them on MFHI/MFLO.
//
//   Optional feature macro: DIVU_ZERO_FAST_EN
//     defined   : divide-by-zero completes in one cycle (IDLE -> DONE directly).
//     undefined : divide-by-zero runs the full WIDTH iterations and produces the
//                 same HiOut = dividend, LoOut = all-ones result.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous active-low reset
//   dataA   in   dividend (unsigned), sampled on the start edge only
//   dataB   in   divisor  (unsigned), sampled on the start edge only
//   Signal  in   6-bit function code; only DIVU has an effect here
//   HiOut   out  remainder of the last completed division (registered)
//   LoOut   out  quotient of the last completed division (registered)
//   busy    out  high while iterating (RUN)
//   done    out  high while in DONE; cleared once Signal leaves DIVU
// -----------------------------------------------------------------------------
module divu_hilo #(
    parameter logic [5:0] DIVU  = 6'b011011,
    parameter int         WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] q_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q;      // latched divisor
    logic [CW-1:0]    cnt_q;    // iteration counter
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic             fit;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] q_d;
    logic             last;
    logic             zero_fast;

    // One restoring-division step.
    // r_shift is the 33-bit shifted remainder. Because the stored remainder is
    // always below the divisor, r_shift < 2*d. A non-negative difference
    // therefore always fits in WIDTH bits. The borrow bit (diff MSB) is then
    // exactly the complement of (r_shift >= {1'b0, d}).
    always_comb begin
        r_shift = {r_q, q_q[WIDTH-1]};
        diff    = r_shift - {1'b0, d_q};
        fit     = ~diff[WIDTH];
        r_d     = fit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], fit};
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef DIVU_ZERO_FAST_EN
    assign zero_fast = (dataB == '0);
`else
    assign zero_fast = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Signal == DIVU) begin
                        if (zero_fast) begin
                            // Short-circuit: the full loop would give the same result.
                            hi_q    <= dataA;
                            lo_q    <= '1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            q_q     <= dataA;
                            d_q     <= dataB;
                            r_q     <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        // Results are published only on the completing edge. An
                        // MFHI/MFLO issued mid-run still sees the prior result.
                        hi_q    <= r_d;
                        lo_q    <= q_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    // A held DIVU code parks here and does not retrigger.
                    if (Signal != DIVU) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_divu_hilo.sv
// -----------------------------------------------------------------------------
// tb_divu_hilo
//   Randomized + directed bench for divu_hilo. Stimulus pushes the expected
//   {remainder, quotient, completion latency} onto a scoreboard queue. A
//   negedge monitor pops and compares it on every rising edge of done. It also
//   checks that busy/done are exclusive and that HiOut/LoOut hold between
//   completions.
// -----------------------------------------------------------------------------
module tb_divu_hilo;

    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] MFHI = 6'b010000;
    localparam logic [5:0] MFLO = 6'b010010;
    localparam logic [5:0] ADD  = 6'b100000;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [31:0] HiOut;
    logic [31:0] LoOut;
    logic        busy;
    logic        done;

    divu_hilo #(.DIVU(DIVU), .WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic rst_edge   = 1'b0;
    logic mon_en     = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= ~reset;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic, with divide-by-zero mapped to
    // remainder = dividend, quotient = all ones.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int start);
        exp_t e;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else begin
            e.hi = a % b;
            e.lo = a / b;
        end
        e.start = start;
        e.lat   = 32;
`ifdef DIVU_ZERO_FAST_EN
        if (b == 32'd0) e.lat = 0;
`endif
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic        done_prev = 1'b0;
    logic [31:0] prev_hi   = '0;
    logic [31:0] prev_lo   = '0;

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_edge) begin
                sb.delete();
            end else begin
                chk("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
                if (done && !done_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("HiOut", {32'd0, HiOut}, {32'd0, e.hi});
                        chk("LoOut", {32'd0, LoOut}, {32'd0, e.lo});
                        chk("latency", 64'(cyc - e.start), 64'(e.lat));
                    end
                end else begin
                    chk("hilo_hold", {HiOut, LoOut}, {prev_hi, prev_lo});
                end
            end
        end
        done_prev = done;
        prev_hi   = HiOut;
        prev_lo   = LoOut;
    end

    // ---------------- stimulus ----------------
    function automatic logic [5:0] pick_code();
        case ($urandom_range(0, 3))
            0:       return MFHI;
            1:       return MFLO;
            2:       return DIVU;
            default: return ADD;
        endcase
    endfunction

    // Issue one division from IDLE, churn inputs while it runs, and return to IDLE.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit hold);
        bit fast;
        bit seen;
        fast = 1'b0;
`ifdef DIVU_ZERO_FAST_EN
        fast = (b == 32'd0);
`endif
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = DIVU;
        sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        chk("busy_after_start", {63'd0, busy}, {63'd0, !fast});
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            dataA  = $urandom;
            dataB  = $urandom;
            Signal = pick_code();
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        if (hold) begin
            Signal = DIVU;
            repeat (50) @(negedge clk);
            chk("hold_state", {62'd0, busy, done}, 64'd1);
        end
        Signal = ADD;
        @(negedge clk);
        chk("done_fall", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        reset  = 1'b0;
        dataA  = '0;
        dataB  = '0;
        Signal = ADD;
        repeat (2) @(negedge clk);
        chk("reset_hi",   {32'd0, HiOut}, 64'd0);
        chk("reset_lo",   {32'd0, LoOut}, 64'd0);
        chk("reset_busy", {63'd0, busy},  64'd0);
        chk("reset_done", {63'd0, done},  64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        do_div(32'd5, 32'hFFFF_FFFF, 1'b0);
        do_div(32'h1234_5678, 32'd0, 1'b0);
        do_div(32'd77, 32'd10, 1'b1);
        do_div(32'd9, 32'd4, 1'b0);

        // Abort at cycle 10 of RUN.
        @(negedge clk);
        dataA  = 32'hDEAD_BEEF;
        dataB  = 32'd3;
        Signal = DIVU;
        sb.push_back(model(32'hDEAD_BEEF, 32'd3, cyc + 1));
        repeat (10) begin
            @(negedge clk);
            Signal = MFLO;
            dataA  = $urandom;
        end
        reset  = 1'b0;
        Signal = ADD;
        @(negedge clk);
        reset = 1'b1;
        chk("midrun_rst", {HiOut, LoOut}, 64'd0);
        chk("midrun_rst_flags", {62'd0, busy, done}, 64'd0);
        do_div(32'd1000, 32'd33, 1'b0);

        for (int k = 0; k < 16; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            do_div(a, b, 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
